// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants and types for the 4-digit multiplexed 7-segment scanner.
package display_pkg;

   localparam int         NUM_DIGITS = 4;
   localparam logic [6:0] SEG_DARK   = 7'h7F;
   localparam logic [3:0] AN_OFF     = 4'hF;

   typedef enum logic {PH_GUARD, PH_SHOW} slot_phase_e;

endpackage

// File: rtl/display_scan_ctrl_hex.sv
// Team hex-to-7-segment decoder, active-low segments with bit0=a ... bit6=g.
module displayHEX
   import display_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_DARK;
      case (i_nib)
         4'h0: o_seg = 7'h40;
         4'h1: o_seg = 7'h79;
         4'h2: o_seg = 7'h24;
         4'h3: o_seg = 7'h30;
         4'h4: o_seg = 7'h19;
         4'h5: o_seg = 7'h12;
         4'h6: o_seg = 7'h02;
         4'h7: o_seg = 7'h78;
         4'h8: o_seg = 7'h00;
         4'h9: o_seg = 7'h10;
         4'hA: o_seg = 7'h08;
         4'hB: o_seg = 7'h03;
         4'hC: o_seg = 7'h46;
         4'hD: o_seg = 7'h21;
         4'hE: o_seg = 7'h06;
         4'hF: o_seg = 7'h0E;
         default: o_seg = SEG_DARK;
      endcase
   end

endmodule

// File: rtl/display_scan_ctrl.sv
// Scans a 16-bit value over four common-anode digits with guard gaps,
// tear-free frame-aligned updates, leading-zero blanking and blink.
module display_scan_ctrl
   import display_pkg::*;
#(
   parameter int SCAN_DIV     = 50000,
   parameter int GUARD        = 16,
   parameter int BLINK_FRAMES = 25
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        LOAD,
   input  logic [15:0] VALUE,
   input  logic        BLANK_LZ,
   input  logic        BLINK,
   output logic [6:0]  SEG,
   output logic [3:0]  AN,
   output logic        PEND,
   output logic        FRAME
);

   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam int DW = $clog2(NUM_DIGITS);

   logic [15:0]   r_act, r_pnd, w_act_nxt, w_pnd_nxt;
   logic          r_pend, w_pend_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [DW-1:0] r_dig, w_dig_nxt;
   logic [BW-1:0] r_bcnt, w_bcnt_nxt;
   logic          r_bph, w_bph_nxt;
   logic          r_lz, r_dark;
   logic [6:0]    r_seg, w_seg_nxt, w_hex;
   logic [3:0]    r_an, w_an_nxt, w_nib;
   logic          r_frame;
   logic          w_bound, w_lz_sup;
   slot_phase_e   w_phase;

   always_comb begin
      w_bound   = (r_cnt == '0) && (r_dig == '0);
      w_phase   = (r_cnt < CW'(GUARD)) ? PH_GUARD : PH_SHOW;
      w_cnt_nxt = r_cnt + CW'(1);
      w_dig_nxt = r_dig;
      if (r_cnt == CW'(SCAN_DIV - 1)) begin
         w_cnt_nxt = '0;
         w_dig_nxt = r_dig + DW'(1);
      end

      // A LOAD on the boundary bypasses the pending register entirely
      w_act_nxt  = r_act;
      w_pnd_nxt  = r_pnd;
      w_pend_nxt = r_pend;
      if (w_bound) begin
         w_pend_nxt = 1'b0;
         if (LOAD)
            w_act_nxt = VALUE;
         else if (r_pend)
            w_act_nxt = r_pnd;
      end else if (LOAD) begin
         w_pnd_nxt  = VALUE;
         w_pend_nxt = 1'b1;
      end

      w_bcnt_nxt = r_bcnt;
      w_bph_nxt  = r_bph;
      if (!BLINK) begin
         w_bcnt_nxt = '0;
         w_bph_nxt  = 1'b0;
      end else if (w_bound) begin
         if (r_bcnt == BW'(BLINK_FRAMES - 1)) begin
            w_bcnt_nxt = '0;
            w_bph_nxt  = ~r_bph;
         end else begin
            w_bcnt_nxt = r_bcnt + BW'(1);
         end
      end

      w_nib    = r_act[{r_dig, 2'b00} +: 4];
      w_lz_sup = r_lz && (r_dig != '0) && ((r_act >> {r_dig, 2'b00}) == 16'h0000);
      w_seg_nxt = SEG_DARK;
      w_an_nxt  = AN_OFF;
      if ((w_phase == PH_SHOW) && !r_dark && !w_lz_sup) begin
         w_an_nxt  = ~(4'b0001 << r_dig);
         w_seg_nxt = w_hex;
      end
   end

   displayHEX u_hex (
      .i_nib (w_nib),
      .o_seg (w_hex)
   );

   // Blank/blink settings are sampled at slot start so a slot never changes mid-way
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_act   <= '0;
         r_pnd   <= '0;
         r_pend  <= 1'b0;
         r_cnt   <= '0;
         r_dig   <= '0;
         r_bcnt  <= '0;
         r_bph   <= 1'b0;
         r_lz    <= 1'b0;
         r_dark  <= 1'b0;
         r_seg   <= SEG_DARK;
         r_an    <= AN_OFF;
         r_frame <= 1'b0;
      end else begin
         r_act   <= w_act_nxt;
         r_pnd   <= w_pnd_nxt;
         r_pend  <= w_pend_nxt;
         r_cnt   <= w_cnt_nxt;
         r_dig   <= w_dig_nxt;
         r_bcnt  <= w_bcnt_nxt;
         r_bph   <= w_bph_nxt;
         if (r_cnt == '0) begin
            r_lz   <= BLANK_LZ;
            r_dark <= w_bph_nxt;
         end
         r_seg   <= w_seg_nxt;
         r_an    <= w_an_nxt;
         r_frame <= w_bound;
      end
   end

   assign SEG   = r_seg;
   assign AN    = r_an;
   assign PEND  = r_pend;
   assign FRAME = r_frame;

endmodule
